approx_add_err_monitor: RTL
===========================

// Module: approx_add_err_monitor
// PURPOSE
//  Streaming error-characterisation engine on the consumer side of an approximate ripple-carry adder.
//  Takes operand pairs and the adder's (W+1)-bit result, and recomputes the exact sum.
//  Over a programmable window it accumulates: error count, sum of squared error (SSE) and max |error|.
//  Sits after the adder in the power/MSE evaluation harness and reports results on a valid/ready port.
// PARAMETERS
//  W      16  operand width; approximate result is W+1 bits
//  CNT_W  32  width of window length and sample/error counters
//  SSE_W  66  SSE accumulator width (>= 2*(W+1)+CNT_W for overflow-free; smaller allowed, saturates)
// PORTS
//  clk        in   1        clock, rising edge
//  rst_n      in   1        asynchronous active-low reset
//  start      in   1        pulse: begin a window (honoured only in IDLE)
//  win_len    in   CNT_W    samples per window, sampled on accepted start
//  busy       out  1        high in every state except IDLE
//  s_valid    in   1        sample valid
//  s_ready    out  1        sample accepted when s_valid & s_ready
//  s_in1      in   W        operand A
//  s_in2      in   W        operand B
//  s_out      in   W+1      approximate adder result for (s_in1, s_in2)
//  r_valid    out  1        report valid
//  r_ready    in   1        report consumed when r_valid & r_ready
//  r_samples  out  CNT_W    samples accumulated
//  r_err_cnt  out  CNT_W    samples with s_out != exact
//  r_sse      out  SSE_W    sum of (s_out - exact)^2
//  r_max_abs  out  W+2      max |s_out - exact|
//  r_ovf      out  1        sticky: SSE saturated during window
//  r_bias     out  SSE_W    signed sum of errors (only with ERR_BIAS_EN)
// BEHAVIOUR
//  Reset:
//   - FSM IDLE; all outputs 0; pipeline valids cleared; accumulators 0.
//  FSM IDLE -> RUN -> DRAIN -> REPORT -> IDLE:
//   - IDLE: start=1 latches win_len, clears all accumulators/counters and r_ovf.
//     Goes to RUN, or to DRAIN if win_len==0.
//   - RUN: s_ready=1 while accepted < win_len. The accept that reaches win_len drops s_ready next cycle -> DRAIN.
//   - DRAIN: s_ready=0; waits until both pipeline stages are empty -> REPORT.
//   - REPORT: r_valid=1, r_* stable until r_ready.
//     On handshake -> IDLE, r_valid=0 next cycle; r_* keep last values.
//  Datapath, 2 stages, no stall (s_ready never depends on r_ready):
//   - S1 (accept edge): exact = s_in1 + s_in2 (W+1 bits, zero-ext); err = signed(s_out) - signed(exact), W+2 bits;
//     abs_err; neq = (err != 0).
//   - S2: sq = err*err (2W+2 bits unsigned); SSE += sq; err_cnt += neq; samples += 1; max_abs = max(max_abs, abs_err).
//   - A sample's contribution is visible in r_* 2 cycles after its accept edge.
//  Arithmetic/limits:
//   - SSE saturates at all-ones and sets r_ovf (sticky until next start).
//   - Counters cannot wrap (bounded by win_len).
//  Boundaries:
//   - start outside IDLE ignored.
//   - win_len==0 -> report of all zeros, r_valid 2 cycles after start.
//   - Back-to-back samples at 1/cycle sustained.
//   - s_valid with s_ready=0 never consumed.
//   - rst_n low mid-window: immediate abort, everything to reset values, no report.
// CONFIGURATION
//  ERR_BIAS_EN defined:
//   - Adds signed accumulator r_bias (SSE_W bits, two's complement), S2: bias += sign-ext(err), wraps silently.
//  ERR_BIAS_EN undefined:
//   - r_bias port and its logic absent; all else identical.
// TESTING
//  1 exact: win_len=4, samples (1,1,2),(0xFFFF,0xFFFF,0x1FFFE),(5,7,12),(0,0,0) -> samples=4, err_cnt=0, sse=0, max_abs=0.
//  2 approx: win_len=2, (1,1,s_out=1),(0x0003,0,s_out=0) -> err -1,-3: err_cnt=2, sse=10, max_abs=3, bias=-4 (if EN).
//  3 zero window: win_len=0, start -> r_valid within 2 cycles, all r_* 0, s_ready stays 0.
//  4 backpressure: after 3-sample window hold r_ready=0 for 10 cycles ->
//    r_valid and r_* stable, start pulses ignored, busy=1; r_ready=1 -> IDLE.
//  5 saturation: SSE_W=8, win_len=2, errors 12 and 12 -> sse=255, r_ovf=1;
//    new start clears r_ovf and accumulators.
//  6 reset mid-run: win_len=100, after 40 accepts pulse rst_n low -> all outputs 0, no r_valid;
//    new 1-sample window reports samples=1.

Source files
------------

// File: rtl/approx_add_err_monitor_if.sv
// Control, sample and report bundle for approx_add_err_monitor.
// r_bias exists only when ERR_BIAS_EN is defined.
interface approx_add_err_monitor_if #(
   parameter int W     = 16,
   parameter int CNT_W = 32,
   parameter int SSE_W = 66
);
   logic             start;
   logic [CNT_W-1:0] win_len;
   logic             busy;

   logic             s_valid;
   logic             s_ready;
   logic [W-1:0]     s_in1;
   logic [W-1:0]     s_in2;
   logic [W:0]       s_out;

   logic             r_valid;
   logic             r_ready;
   logic [CNT_W-1:0] r_samples;
   logic [CNT_W-1:0] r_err_cnt;
   logic [SSE_W-1:0] r_sse;
   logic [W+1:0]     r_max_abs;
   logic             r_ovf;

`ifdef ERR_BIAS_EN
   logic [SSE_W-1:0] r_bias;

   modport master (
      output start, win_len, s_valid, s_in1, s_in2, s_out, r_ready,
      input  busy, s_ready, r_valid, r_samples, r_err_cnt, r_sse, r_max_abs, r_ovf, r_bias
   );
   modport slave (
      input  start, win_len, s_valid, s_in1, s_in2, s_out, r_ready,
      output busy, s_ready, r_valid, r_samples, r_err_cnt, r_sse, r_max_abs, r_ovf, r_bias
   );
`else
   modport master (
      output start, win_len, s_valid, s_in1, s_in2, s_out, r_ready,
      input  busy, s_ready, r_valid, r_samples, r_err_cnt, r_sse, r_max_abs, r_ovf
   );
   modport slave (
      input  start, win_len, s_valid, s_in1, s_in2, s_out, r_ready,
      output busy, s_ready, r_valid, r_samples, r_err_cnt, r_sse, r_max_abs, r_ovf
   );
`endif
endinterface

// File: rtl/approx_add_err_monitor.sv
// Windowed error count / SSE / max|err| monitor for an approximate adder; ERR_BIAS_EN adds a signed error sum.
// Latency: a sample lands in r_* on the second edge after its accept; win_len==0 reports 2 cycles after start.
// Backpressure: s_ready never depends on r_ready; an unconsumed report holds r_* and blocks new windows.
module approx_add_err_monitor #(
   parameter int W     = 16,
   parameter int CNT_W = 32,
   parameter int SSE_W = 66
) (
   input  logic clk,
   input  logic rst_n,
   approx_add_err_monitor_if.slave bus
);
   localparam int EW    = W + 2;
   localparam int SQ_W  = 2*W + 2;
   localparam int SUM_W = ((SSE_W > SQ_W) ? SSE_W : SQ_W) + 1;
   localparam logic [SUM_W-1:0] SSE_MAX = {{(SUM_W-SSE_W){1'b0}}, {SSE_W{1'b1}}};

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, REPORT} state_t;

   typedef struct packed {
      logic          neq;
      logic [EW-1:0] abs_err;
`ifdef ERR_BIAS_EN
      logic [EW-1:0] err;
`endif
   } s1_t;

   state_t           state;
   logic             busy_q;
   logic             s_ready_q;
   logic             r_valid_q;
   logic [CNT_W-1:0] win_len_q;
   logic [CNT_W-1:0] acc_cnt;

   logic             s1_vld;
   logic             s2_vld;
   s1_t              s1_q;
   s1_t              s1_d;

   logic [CNT_W-1:0] samples;
   logic [CNT_W-1:0] err_cnt;
   logic [SSE_W-1:0] sse;
   logic [EW-1:0]    max_abs;
   logic             ovf;
`ifdef ERR_BIAS_EN
   logic [SSE_W-1:0] bias;
`endif

   logic             accept;
   logic             clr;
   logic [W:0]       exact;
   logic [EW-1:0]    err;
   logic [SQ_W-1:0]  sq;
   logic [SUM_W-1:0] sse_sum;

   assign accept = bus.s_valid & s_ready_q;
   assign clr    = (state == IDLE) & bus.start;

   // Both the adder result and the exact sum are magnitudes; one extra bit holds the signed difference.
   assign exact = {1'b0, bus.s_in1} + {1'b0, bus.s_in2};
   assign err   = {1'b0, bus.s_out} - {1'b0, exact};

   always_comb begin
      s1_d         = '0;
      s1_d.neq     = (err != '0);
      s1_d.abs_err = err[EW-1] ? (~err + EW'(1)) : err;
`ifdef ERR_BIAS_EN
      s1_d.err     = err;
`endif
   end

   assign sq      = SQ_W'(s1_q.abs_err) * SQ_W'(s1_q.abs_err);
   assign sse_sum = SUM_W'(sse) + SUM_W'(sq);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld  <= 1'b0;
         s2_vld  <= 1'b0;
         s1_q    <= '0;
         samples <= '0;
         err_cnt <= '0;
         sse     <= '0;
         max_abs <= '0;
         ovf     <= 1'b0;
`ifdef ERR_BIAS_EN
         bias    <= '0;
`endif
      end else begin
         s1_vld <= accept;
         s2_vld <= s1_vld;
         if (accept) begin
            s1_q <= s1_d;
         end
         if (clr) begin
            samples <= '0;
            err_cnt <= '0;
            sse     <= '0;
            max_abs <= '0;
            ovf     <= 1'b0;
`ifdef ERR_BIAS_EN
            bias    <= '0;
`endif
         end else if (s1_vld) begin
            samples <= samples + CNT_W'(1);
            err_cnt <= err_cnt + CNT_W'(s1_q.neq);
            // Clamp at all-ones; the overflow flag stays set until the next window starts.
            if (sse_sum > SSE_MAX) begin
               sse <= '1;
               ovf <= 1'b1;
            end else begin
               sse <= sse_sum[SSE_W-1:0];
            end
            if (s1_q.abs_err > max_abs) begin
               max_abs <= s1_q.abs_err;
            end
`ifdef ERR_BIAS_EN
            bias <= bias + SSE_W'($signed(s1_q.err));
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         busy_q    <= 1'b0;
         s_ready_q <= 1'b0;
         r_valid_q <= 1'b0;
         win_len_q <= '0;
         acc_cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  win_len_q <= bus.win_len;
                  acc_cnt   <= '0;
                  busy_q    <= 1'b1;
                  if (bus.win_len == '0) begin
                     state <= DRAIN;
                  end else begin
                     state     <= RUN;
                     s_ready_q <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (accept) begin
                  acc_cnt <= acc_cnt + CNT_W'(1);
                  if (acc_cnt + CNT_W'(1) == win_len_q) begin
                     s_ready_q <= 1'b0;
                     state     <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               // Report only once the last accepted sample has passed both stages.
               if (!s1_vld && !s2_vld) begin
                  state     <= REPORT;
                  r_valid_q <= 1'b1;
               end
            end
            REPORT: begin
               if (bus.r_ready) begin
                  state     <= IDLE;
                  r_valid_q <= 1'b0;
                  busy_q    <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.s_ready   = s_ready_q;
   assign bus.r_valid   = r_valid_q;
   assign bus.r_samples = samples;
   assign bus.r_err_cnt = err_cnt;
   assign bus.r_sse     = sse;
   assign bus.r_max_abs = max_abs;
   assign bus.r_ovf     = ovf;
`ifdef ERR_BIAS_EN
   assign bus.r_bias    = bias;
`endif
endmodule
